// File: rtl/axil_sram_bridge.sv
// AXI4-Lite slave bridging single transactions onto a single-port synchronous SRAM.
// One outstanding access; writes start only when AWVALID and WVALID coincide.
module axil_sram_bridge #(
    parameter logic [31:0] ADDR_BASE  = 32'h2000_0000,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter bit          ERR_EN     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [31:0]           s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  sram_en_o,
    output logic                  sram_we_o,
    output logic [3:0]            sram_wem_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]           sram_wdata_o,
    input  logic [31:0]           sram_rdata_i
);

    typedef enum logic [2:0] {
        IDLE, WR_EXE, WR_RESP, RD_EXE, RD_WAIT, RD_RESP
    } state_e;

    localparam int unsigned TAG_LSB  = ADDR_WIDTH + 2;
    localparam logic [1:0]  OKAY     = 2'b00;
    localparam logic [1:0]  RESP_OOW = ERR_EN ? 2'b10 : 2'b00;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  idle, aw_in_win, ar_in_win;
    logic                  unused_ok;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign aw_in_win = (s_axi_awaddr[31:TAG_LSB] == ADDR_BASE[31:TAG_LSB]);
    assign ar_in_win = (s_axi_araddr[31:TAG_LSB] == ADDR_BASE[31:TAG_LSB]);

    // Readies come from the state register only; held low while reset is asserted.
    assign idle          = (state_q == IDLE) && rst_n;
    assign s_axi_awready = idle;
    assign s_axi_wready  = idle;
    assign s_axi_arready = idle;

    assign s_axi_bvalid  = (state_q == WR_RESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = (state_q == RD_RESP);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    assign sram_en_o     = (state_q == WR_EXE) || (state_q == RD_EXE);
    assign sram_we_o     = (state_q == WR_EXE);
    assign sram_addr_o   = addr_q;
    assign sram_wem_o    = wstrb_q;
    assign sram_wdata_o  = wdata_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        bresp_d = bresp_q;
        rresp_d = rresp_q;
        case (state_q)
            IDLE: begin
                if (s_axi_awvalid && s_axi_wvalid) begin
                    addr_d  = s_axi_awaddr[TAG_LSB-1:2];
                    wdata_d = s_axi_wdata;
                    wstrb_d = s_axi_wstrb;
                    if (aw_in_win) begin
                        bresp_d = OKAY;
                        state_d = WR_EXE;
                    end else begin
                        bresp_d = RESP_OOW;
                        state_d = WR_RESP;
                    end
                end else if (s_axi_arvalid) begin
                    addr_d = s_axi_araddr[TAG_LSB-1:2];
                    if (ar_in_win) begin
                        rresp_d = OKAY;
                        state_d = RD_EXE;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_OOW;
                        state_d = RD_RESP;
                    end
                end
            end
            WR_EXE:  state_d = WR_RESP;
            WR_RESP: if (s_axi_bready) state_d = IDLE;
            RD_EXE:  state_d = RD_WAIT;
            RD_WAIT: begin
                rdata_d = sram_rdata_i;
                state_d = RD_RESP;
            end
            RD_RESP: if (s_axi_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            bresp_q <= '0;
            rresp_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            bresp_q <= bresp_d;
            rresp_q <= rresp_d;
        end
    end

endmodule

// File: doc/axil_sram_bridge.md
Name: axil_sram_bridge

Overview:
AXI4-Lite slave that sits directly downstream of the core's bus/stall controller master port and converts its transactions into single-port synchronous SRAM accesses (data RAM / peripheral RAM window). One outstanding transaction at a time, registered SRAM interface, fixed latencies. It tolerates the master's behaviour of raising AWVALID during reads: a write is started only when AWVALID and WVALID are high in the same cycle.

Parameters:
ADDR_BASE, 32'h2000_0000, byte base address of the window; must be aligned to 4*2^ADDR_WIDTH.
ADDR_WIDTH, 14, SRAM word-address bits; the window is 4*2^ADDR_WIDTH bytes.
ERR_EN, 0, 1: out-of-window access returns SLVERR (2'b10). 0: returns OKAY with read data 0 and the write dropped.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axi_awaddr  in  32  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  32  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
sram_en_o  out  1  SRAM access enable
sram_we_o  out  1  SRAM write enable
sram_wem_o  out  4  SRAM byte write mask
sram_addr_o  out  ADDR_WIDTH  SRAM word address
sram_wdata_o  out  32  SRAM write data
sram_rdata_i  in  32  SRAM read data, valid the cycle after the sram_en_o cycle

Behaviour:
- One clock domain, clk. rst_n is asynchronous, active-low; asserting it forces state IDLE and all registered outputs to 0. An in-flight transaction is dropped with no response.
- Reset values: every output is 0 except the ready signals, which become 1 once IDLE is reached.
- States: IDLE, WR_EXE, WR_RESP, RD_EXE, RD_WAIT, RD_RESP.
- s_axi_awready, s_axi_wready and s_axi_arready are each asserted exactly when state==IDLE. They are decoded from the state register and do not depend on any valid signal.
- IDLE priority:
  - Write start: awvalid & wvalid in the same cycle. Latch address, data and strobe.
  - Else read start: arvalid. Latch the address.
  - awvalid alone or wvalid alone is ignored; nothing is latched.
  - When awvalid, wvalid and arvalid are all high, the write wins and the read waits in IDLE.
- In-window test: addr[31:ADDR_WIDTH+2] == ADDR_BASE[31:ADDR_WIDTH+2]. SRAM word address = addr[ADDR_WIDTH+1:2]. Addr[1:0] is ignored.
- Write, in-window (handshake in cycle T):
  - Cycle T+1, WR_EXE: sram_en_o=1, sram_we_o=1, sram_wem_o=wstrb, sram_wdata_o=wdata.
  - Cycle T+2: WR_RESP, s_axi_bvalid=1, bresp=OKAY.
- Write, out-of-window: WR_EXE is skipped and no SRAM access occurs. bvalid rises at T+1 with bresp = ERR_EN ? 2'b10 : 2'b00.
- Read, in-window (handshake in cycle T):
  - Cycle T+1, RD_EXE: sram_en_o=1, sram_we_o=0.
  - Cycle T+2, RD_WAIT: capture sram_rdata_i.
  - Cycle T+3: RD_RESP, rvalid=1, rdata = captured word, rresp=OKAY.
- Read, out-of-window: rvalid rises at T+1 with rdata=0 and rresp = ERR_EN ? 2'b10 : 2'b00.
- Response phase: bvalid/rvalid, together with their data and resp, stay stable until the matching ready is sampled high. In that cycle valid drops on the next edge and the state returns to IDLE, so the next handshake can occur no earlier than the cycle after.
- sram_en_o and sram_we_o are 1-cycle pulses, 0 in every other state. sram_addr_o, sram_wem_o and sram_wdata_o hold the last latched values.
- wstrb=4'b0000 in-window still performs the SRAM cycle with mask 0 and returns OKAY.
- Edge addresses: ADDR_BASE + 4*2^ADDR_WIDTH - 4 is in-window. ADDR_BASE + 4*2^ADDR_WIDTH and ADDR_BASE - 4 are out-of-window.

Test Plan:
- Write 0x2000_0010, data 0xDEAD_BEEF, strb 4'hF, bready=1 -> T+1: en=1, we=1, addr=4, wem=F. T+2: bvalid=1, bresp=00. Then a read of the same address -> rvalid at T+3, rdata=0xDEAD_BEEF.
- awvalid=1, wvalid=0, arvalid=1, araddr 0x2000_0010 -> treated as a read: no SRAM write pulse, rvalid at T+3.
- Write strb 4'b0010, data 0x0000_AB00 over 0xDEAD_BEEF -> sram_wem_o=2. Readback gives 0xDEAD_ABEF (bench SRAM model).
- ERR_EN=1: read 0x2001_0000 (ADDR_WIDTH=14) -> rvalid at T+1, rresp=10, rdata=0, no sram_en_o. With ERR_EN=0: rresp=00, rdata=0. Address 0x2000_FFFC -> OKAY.
- rready held 0 for 5 cycles after rvalid -> rvalid, rdata and rresp stable, arready=0 throughout. Release -> IDLE next cycle.
- rst_n pulsed low during RD_WAIT -> all outputs 0 immediately. After release: IDLE, readies=1, no stale rvalid.
